// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  // Quotient reported when the divisor is zero
  localparam logic [DIV_WIDTH-1:0] DIV_DZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference or restore.
module div_step
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The incoming remainder is always below the divisor, so WIDTH+1 bits hold
  // the shifted value and diff[WIDTH] is a true borrow.
  always_comb begin
    shifted = (WIDTH+1)'({rem_in, dvd_bit});
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/divider32_seq.sv
// Multi-cycle restoring divider with start/busy/done handshake.
// Optional macro DIVIDER_SIGNED_EN selects two's complement (div) operation;
// without it operands are unsigned (divu).
module divider32_seq
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_raw, r_raw;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             a_neg, b_neg;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Final step results: quotient bits accumulate in the dividend shift register
  assign q_raw = {dvd_q[WIDTH-2:0], step_q};
  assign r_raw = step_rem[WIDTH-1:0];

`ifdef DIVIDER_SIGNED_EN
  assign a_neg = dividend[WIDTH-1];
  assign b_neg = divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;
  assign q_fix = qneg_q ? -q_raw : q_raw;
  assign r_fix = rneg_q ? -r_raw : r_raw;
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fix = q_raw;
  assign r_fix = r_raw;
`endif

  // Next-state, datapath and result update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          dvd_d  = a_mag;
          dvs_d  = b_mag;
          rem_d  = '0;
          cnt_d  = '0;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (divisor == '0) begin
            state_d = FIN;
            quot_d  = '1;
            remo_d  = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else if (state_q == FIN) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d = step_rem;
        dvd_d = q_raw;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = FIN;
          quot_d  = q_fix;
          remo_d  = r_fix;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      quot_q <= '0;
      remo_q <= '0;
      dbz_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      quot_q <= quot_d;
      remo_q <= remo_d;
      dbz_q  <= dbz_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == FIN);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider32_seq.sv
// Directed self-checking bench for divider32_seq (unsigned or signed build).
module tb_divider32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  divider32_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] q, input logic [31:0] r,
                              input logic dz);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Start an operation at the next edge, scramble the inputs afterwards, and
  // wait (bounded) for done. lat counts cycles from the start edge to done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = ~a; divisor = b ^ 32'h5;
    lat = 1; bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int lat, bcnt, cyc, bad;

    vecs.push_back(mk(32'd100,        32'd7,        32'd14,       32'd2,        1'b0));
    vecs.push_back(mk(32'd25,         32'd0,        32'hFFFFFFFF, 32'd25,       1'b1));
    vecs.push_back(mk(32'd5,          32'd9,        32'd0,        32'd5,        1'b0));
    vecs.push_back(mk(32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0,        1'b0));
    vecs.push_back(mk(32'd1000,       32'd10,       32'd100,      32'd0,        1'b0));
    vecs.push_back(mk(32'd0,          32'd5,        32'd0,        32'd0,        1'b0));
    vecs.push_back(mk(32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        32'd0,        1'b0));
    vecs.push_back(mk(32'h0000DEAD,   32'h10,       32'h00000DEA, 32'hD,        1'b0));
`ifdef DIVIDER_SIGNED_EN
    vecs.push_back(mk(32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0));
    vecs.push_back(mk(32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0));
    vecs.push_back(mk(32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0));
    vecs.push_back(mk(32'h80000000,   32'd2,        32'hC0000000, 32'd0,        1'b0));
    vecs.push_back(mk(32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0));
    vecs.push_back(mk(32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1));
`else
    vecs.push_back(mk(32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC, 32'd1,        1'b0));
    vecs.push_back(mk(32'd7,          32'hFFFFFFFE, 32'd0,        32'd7,        1'b0));
    vecs.push_back(mk(32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0));
    vecs.push_back(mk(32'h80000000,   32'd2,        32'h40000000, 32'd0,        1'b0));
`endif

    // Reset then idle
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_quot", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 32'd0);

    // Table: consecutive operations start in the previous done cycle
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("v%0d_lat", i), lat, vecs[i].dz ? 32'd1 : 32'd33);
      check($sformatf("v%0d_busy", i), bcnt, vecs[i].dz ? 32'd0 : 32'd32);
      check($sformatf("v%0d_quot", i), quotient, vecs[i].q);
      check($sformatf("v%0d_rem", i), remainder, vecs[i].r);
      check($sformatf("v%0d_dbz", i), {31'b0, div_by_zero}, {31'b0, vecs[i].dz});
    end
    repeat (3) @(posedge clk);

    // start mid-RUN with new operands is ignored
    @(negedge clk); start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    repeat (5) @(posedge clk);
    cyc += 5;
    @(negedge clk); start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1; start = 1'b0; cyc++;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("midrun_lat", cyc, 32'd33);
    check("midrun_quot", quotient, 32'd14);
    check("midrun_rem", remainder, 32'd2);
    @(posedge clk); #1;
    check("midrun_after_done", {31'b0, done}, 32'd0);
    check("midrun_after_busy", {31'b0, busy}, 32'd0);
    check("midrun_hold_quot", quotient, 32'd14);

    // Back-to-back: start during the done cycle
    run_op(32'd1000, 32'd10, lat, bcnt);
    check("b2b_first_quot", quotient, 32'd100);
    @(negedge clk); start = 1'b1; dividend = 32'd9; divisor = 32'd4;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    check("b2b_done_drop", {31'b0, done}, 32'd0);
    check("b2b_busy_rise", {31'b0, busy}, 32'd1);
    check("b2b_hold_quot", quotient, 32'd100);
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("b2b_lat", cyc, 32'd33);
    check("b2b_quot", quotient, 32'd2);
    check("b2b_rem", remainder, 32'd1);

    // Asynchronous reset at step 10 aborts immediately
    @(negedge clk); start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_quot", quotient, 32'd0);
    check("abort_rem", remainder, 32'd0);
    check("abort_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk); reset = 1'b0;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("abort_quiet", bad, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider32_seq.md
# divider32_seq

Multi-cycle 32-bit restoring divider that complements the single-cycle 32-bit adder in the datapath. It computes quotient and remainder by one trial subtraction per clock and serves the `div`/`divu` instructions. It sits beside the ALU, and the control unit stalls on `busy`. A start/busy/done handshake replaces the adder's purely combinational interface.

## Interface
- `WIDTH`, default 32, operand and result width in bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a division; sampled only when `busy`=0.
- `dividend`  in  WIDTH  numerator; latched on an accepted start.
- `divisor`  in  WIDTH  denominator; latched on an accepted start.
- `busy`  out  WIDTH-independent 1  high while a division is in progress.
- `done`  out  1  one-cycle pulse marking valid results.
- `quotient`  out  WIDTH  result quotient; held until the next accepted start.
- `remainder`  out  WIDTH  result remainder; held until the next accepted start.
- `div_by_zero`  out  1  set with `done` when the latched divisor was 0; held with the results.

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE/FIN with `start`=1:
  - latch operand magnitudes;
  - clear the partial remainder;
  - step counter to 0;
  - go to RUN, or to FIN directly if the divisor is 0.
- IDLE without `start`: stay in IDLE.
- FIN without `start`: go to IDLE.
- RUN, each cycle:
  - shift {partial remainder, dividend} left by 1;
  - trial-subtract the divisor from the partial remainder;
  - if the result is non-negative, keep it and set the quotient LSB to 1, otherwise restore and set it to 0;
  - increment the counter.
- After step WIDTH-1, register the final quotient and remainder, then go to FIN.
- `start` while in RUN is ignored; operand changes during RUN have no effect.
- Divide by zero: `quotient` = all ones, `remainder` = `dividend`, `div_by_zero` = 1.
- All arithmetic is unsigned magnitude of WIDTH bits. The partial remainder is WIDTH+1 bits wide, so the subtraction borrow is visible.
- Outputs in IDLE and RUN keep the previous results.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0; state IDLE; counter 0.
- Reset asserted mid-operation aborts the division immediately; there is no partial result.
- `start` is accepted on edge k.
- `busy` is high from after edge k until after edge k+WIDTH, i.e. exactly WIDTH cycles.
- `done` is high for the one cycle after edge k+WIDTH, and the results are valid in that same cycle.
- Divide by zero: `busy` stays low, and `done` pulses in the cycle after edge k (latency 1).
- Back-to-back operation: a start during the `done` cycle is accepted. `done` drops and `busy` rises on the next edge, giving WIDTH+1 cycles per operation.

## Configuration
- Macro `DIVIDER_SIGNED_EN`.
- Defined: operands are two's complement (`div` semantics).
  - Magnitudes are taken at latch time.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend. The fixup is applied on the transition to FIN and adds no cycle.
  - -2^31 / -1 gives `quotient`=0x80000000, `remainder`=0.
  - Divide by zero still returns all ones / `dividend`.
- Undefined: operands are unsigned (`divu` semantics) and no sign logic is built.

## Structure
- Package `divider_pkg`:
  - state enum {IDLE, RUN, FIN};
  - `DIV_WIDTH`=32;
  - counter width constant `$clog2(DIV_WIDTH)`;
  - divide-by-zero quotient constant (all ones).
- One combinational sub-module `div_step`. It takes the partial remainder, the incoming dividend bit and the divisor, and returns the next partial remainder and the quotient bit.
- The FSM, counter and sign fixup stay in the top module.

## Test plan
- Reset then idle: `reset` pulse, no `start` → all outputs 0; `busy` never rises.
- Unsigned basic: 100 / 7, start at edge k → `busy` for 32 cycles; `done` after edge k+32 with `quotient`=14, `remainder`=2; `div_by_zero`=0.
- Divide by zero: 25 / 0 → `done` one cycle after the start edge; `quotient`=0xFFFFFFFF, `remainder`=25, `div_by_zero`=1; `busy` never high.
- Edge magnitudes: 0xFFFFFFFF / 1 → `quotient`=0xFFFFFFFF, `remainder`=0 (unsigned build); 5 / 9 → `quotient`=0, `remainder`=5.
- Signed (`DIVIDER_SIGNED_EN`):
  - -7 / 2 → `quotient`=-3, `remainder`=-1;
  - 7 / -2 → -3, 1;
  - 0x80000000 / -1 → 0x80000000, 0.
- Handshake and abort:
  - `start` pulsed mid-RUN with new operands → ignored; first result unchanged;
  - `start` during the `done` cycle → the new operation is accepted;
  - `reset` asserted at step 10 → IDLE, all outputs 0 immediately.
